cond_exec_unit: RTL and testbench
=================================

COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; clears all state.
REQ-004 stall  input  1  hold the E-stage register and suppress commit this cycle.
REQ-005 flush  input  1  load a bubble into the E-stage register.
REQ-006 d_cond  input  4  condition field of the decoded instruction (instr[31:28]).
REQ-007 d_pcs, d_reg_w, d_mem_w, d_mem_to_reg, d_alu_src, d_no_write  input  1 each  decoder control bits.
REQ-008 d_flag_w  input  2  [1] writes N,Z; [0] writes C,V.
REQ-009 d_alu_control  input  2  ALU operation select.
REQ-010 alu_flags  input  4  {N,Z,C,V} produced by the ALU for the E-stage instruction.
REQ-011 e_alu_control  output  2; e_alu_src, e_mem_to_reg  output  1 each  registered pass-through to the execute datapath.
REQ-012 e_valid  output  1  the E-stage register holds a real instruction.
REQ-013 cond_ex  output  1  the E-stage condition passes against the flag register.
REQ-014 pc_src, reg_write, mem_write  output  1 each  gated commit strobes.
REQ-015 flags  output  4  current {N,Z,C,V} flag register.

Function
REQ-016 The E-stage register SHALL capture cond, pcs, reg_w, mem_w, mem_to_reg, alu_src, no_write, flag_w, and alu_control on each rising edge.
REQ-017 Edge priority SHALL be: reset, then flush, then stall, then load; flush with stall loads a bubble.
REQ-018 Bubble/flush SHALL load all E-stage control bits with 0 and e_valid with 0; a load SHALL set e_valid to 1.
REQ-019 stall=1 without flush SHALL hold every E-stage bit and the flag register unchanged.
REQ-020 cond_ex SHALL be a combinational function of e_cond and the flag register (pre-update values) as follows:
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: N
- 0101 PL: !N
- 0110 VS: V
- 0111 VC: !V
- 1000 HI: C&!Z
- 1001 LS: !C|Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: !Z&(N==V)
- 1101 LE: Z|(N!=V)
- 1110 AL: 1
- 1111: 0
REQ-021 The commit qualifier SHALL be e_valid & cond_ex & !stall.
REQ-022 pc_src SHALL equal commit qualifier & e_pcs.
REQ-023 mem_write SHALL equal commit qualifier & e_mem_w.
REQ-024 reg_write SHALL equal commit qualifier & e_reg_w & !e_no_write.
REQ-025 When commit qualifier=1 and e_flag_w[1]=1, N,Z SHALL load alu_flags[3:2] at the edge.
REQ-026 When commit qualifier=1 and e_flag_w[0]=1, C,V SHALL load alu_flags[1:0] at the edge.
REQ-027 Flag bits not selected by e_flag_w SHALL hold.
REQ-028 A failed condition SHALL suppress the flag update as well as all strobes.
REQ-029 Latency SHALL be one cycle from d_* to the E-stage outputs.
REQ-030 A flag update SHALL be visible to the next E-stage instruction's cond_ex, with no internal bypass.
REQ-031 pc_src=1 SHALL NOT self-flush; flush is driven externally.

Reset
REQ-032 On reset, the E-stage register SHALL be a bubble (all control 0, e_valid=0) and flags SHALL be 4'b0000.
REQ-033 In the cycle after reset, pc_src, reg_write, mem_write, e_* and cond_ex SHALL be 0.
REQ-034 Reset mid-stall or mid-flush SHALL take precedence and give the same result as REQ-032.

Verification
REQ-035 After reset, load ADDS (cond=1110, reg_w=1, flag_w=11) with alu_flags=0100 -> reg_write=1; flags=0100 next cycle.
REQ-036 Then load BEQ (cond=0000, pcs=1) -> pc_src=1.
REQ-037 With flags=0000, load BNE-style MOVEQ (cond=0000, reg_w=1) -> reg_write=0, flags unchanged.
REQ-038 Load CMP (no_write=1, flag_w=11, cond=1110) with alu_flags=1000 -> reg_write=0; flags=1000; next GE (1010) gives cond_ex=0 and LT (1011) gives cond_ex=1.
REQ-039 Hold STR (mem_w=1) under stall for 3 cycles -> mem_write=0 for 3 cycles, then 1 for exactly one cycle after release; flags unchanged during stall.
REQ-040 Assert flush and stall together with ADDS pending -> e_valid=0 next cycle, all strobes 0, flags unchanged.

Source files
------------

// File: rtl/cond_exec_unit.sv
// cond_exec_unit: execute-stage control register with conditional execution.
// Captures decoded control bits into the E-stage register and evaluates the
// ARM-style condition field against the {N,Z,C,V} flag register. It gates the
// commit strobes and flag writes with the condition result. Flag updates take
// effect at the commit edge and are seen only by the following instruction.
module cond_exec_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  logic [3:0] d_cond,
    input  logic       d_pcs,
    input  logic       d_reg_w,
    input  logic       d_mem_w,
    input  logic       d_mem_to_reg,
    input  logic       d_alu_src,
    input  logic       d_no_write,
    input  logic [1:0] d_flag_w,
    input  logic [1:0] d_alu_control,
    input  logic [3:0] alu_flags,
    output logic [1:0] e_alu_control,
    output logic       e_alu_src,
    output logic       e_mem_to_reg,
    output logic       e_valid,
    output logic       cond_ex,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic [3:0] flags
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    // E-stage register contents
    cond_t      e_cond;
    logic       e_pcs;
    logic       e_reg_w;
    logic       e_mem_w;
    logic       e_no_write;
    logic [1:0] e_flag_w;

    // Flag register fields
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;

    logic       commit;

    // E-stage register: reset/flush load a bubble, stall holds, otherwise load
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            e_valid       <= 1'b0;
            e_cond        <= COND_EQ;
            e_pcs         <= 1'b0;
            e_reg_w       <= 1'b0;
            e_mem_w       <= 1'b0;
            e_mem_to_reg  <= 1'b0;
            e_alu_src     <= 1'b0;
            e_no_write    <= 1'b0;
            e_flag_w      <= '0;
            e_alu_control <= '0;
        end else if (!stall) begin
            e_valid       <= 1'b1;
            e_cond        <= cond_t'(d_cond);
            e_pcs         <= d_pcs;
            e_reg_w       <= d_reg_w;
            e_mem_w       <= d_mem_w;
            e_mem_to_reg  <= d_mem_to_reg;
            e_alu_src     <= d_alu_src;
            e_no_write    <= d_no_write;
            e_flag_w      <= d_flag_w;
            e_alu_control <= d_alu_control;
        end
    end

    // Condition check against the current (pre-update) flag register
    always_comb begin
        cond_ex = 1'b0;
        case (e_cond)
            COND_EQ: cond_ex = flag_z;
            COND_NE: cond_ex = !flag_z;
            COND_CS: cond_ex = flag_c;
            COND_CC: cond_ex = !flag_c;
            COND_MI: cond_ex = flag_n;
            COND_PL: cond_ex = !flag_n;
            COND_VS: cond_ex = flag_v;
            COND_VC: cond_ex = !flag_v;
            COND_HI: cond_ex = flag_c && !flag_z;
            COND_LS: cond_ex = !flag_c || flag_z;
            COND_GE: cond_ex = (flag_n == flag_v);
            COND_LT: cond_ex = (flag_n != flag_v);
            COND_GT: cond_ex = !flag_z && (flag_n == flag_v);
            COND_LE: cond_ex = flag_z || (flag_n != flag_v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Commit qualifier and gated strobes; a taken branch does not flush here
    always_comb begin
        commit    = e_valid && cond_ex && !stall;
        pc_src    = commit && e_pcs;
        mem_write = commit && e_mem_w;
        reg_write = commit && e_reg_w && !e_no_write;
    end

    // Flag register: each half updates only on a committed, selected write
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            if (commit && e_flag_w[1]) begin
                flag_n <= alu_flags[3];
                flag_z <= alu_flags[2];
            end
            if (commit && e_flag_w[0]) begin
                flag_c <= alu_flags[1];
                flag_v <= alu_flags[0];
            end
        end
    end

    // Flag register exported as {N,Z,C,V}
    always_comb begin
        flags = {flag_n, flag_z, flag_c, flag_v};
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed testbench for cond_exec_unit with hand-computed expectations.
module tb_cond_exec_unit;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       flush;
    logic [3:0] d_cond;
    logic       d_pcs;
    logic       d_reg_w;
    logic       d_mem_w;
    logic       d_mem_to_reg;
    logic       d_alu_src;
    logic       d_no_write;
    logic [1:0] d_flag_w;
    logic [1:0] d_alu_control;
    logic [3:0] alu_flags;
    logic [1:0] e_alu_control;
    logic       e_alu_src;
    logic       e_mem_to_reg;
    logic       e_valid;
    logic       cond_ex;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] flags;

    int unsigned n_cmp;
    int unsigned n_bad;

    cond_exec_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .d_cond       (d_cond),
        .d_pcs        (d_pcs),
        .d_reg_w      (d_reg_w),
        .d_mem_w      (d_mem_w),
        .d_mem_to_reg (d_mem_to_reg),
        .d_alu_src    (d_alu_src),
        .d_no_write   (d_no_write),
        .d_flag_w     (d_flag_w),
        .d_alu_control(d_alu_control),
        .alu_flags    (alu_flags),
        .e_alu_control(e_alu_control),
        .e_alu_src    (e_alu_src),
        .e_mem_to_reg (e_mem_to_reg),
        .e_valid      (e_valid),
        .cond_ex      (cond_ex),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .flags        (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a decoded instruction: {cond, pcs, reg_w, mem_w, no_write, flag_w}
    task automatic set_d(input logic [3:0] c, input logic p, input logic rw,
                         input logic mw, input logic nw, input logic [1:0] fw);
        d_cond        = c;
        d_pcs         = p;
        d_reg_w       = rw;
        d_mem_w       = mw;
        d_no_write    = nw;
        d_flag_w      = fw;
        d_mem_to_reg  = 1'b0;
        d_alu_src     = 1'b0;
        d_alu_control = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a flag-free instruction with the given condition and return cond_ex
    task automatic probe_cond(input logic [3:0] c, input string tag, input logic exp);
        set_d(c, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();
        check(tag, {7'b0, cond_ex}, {7'b0, exp});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        stall = 1'b1;
        flush = 1'b1;
        alu_flags = 4'b1111;
        set_d(4'b1110, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
        d_alu_control = 2'b11;
        d_alu_src = 1'b1;
        d_mem_to_reg = 1'b1;

        // Reset while stall and flush are both asserted
        reset = 1'b1;
        tick();
        tick();
        check("rst_valid", {7'b0, e_valid}, 8'h00);
        check("rst_flags", {4'b0, flags}, 8'h00);
        check("rst_strobes", {5'b0, pc_src, reg_write, mem_write}, 8'h00);
        check("rst_cond_ex", {7'b0, cond_ex}, 8'h00);
        check("rst_e_pass", {4'b0, e_alu_control, e_alu_src, e_mem_to_reg}, 8'h00);
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;

        // ADDS: AL, reg_w, flag_w=11, with pass-through fields set
        set_d(4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
        d_alu_control = 2'b01;
        d_alu_src = 1'b1;
        tick();
        alu_flags = 4'b0100;
        #1;
        check("adds_valid", {7'b0, e_valid}, 8'h01);
        check("adds_pass", {5'b0, e_alu_control, e_alu_src}, 8'h03);
        check("adds_reg_write", {7'b0, reg_write}, 8'h01);
        check("adds_flags_pre", {4'b0, flags}, 8'h00);

        // BEQ with Z=1 is taken; next instruction is still valid (no self-flush)
        set_d(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        tick();
        check("adds_flags_post", {4'b0, flags}, 8'h04);
        check("beq_pc_src", {7'b0, pc_src}, 8'h01);
        check("beq_reg_write", {7'b0, reg_write}, 8'h00);

        // CMP AL clears flags to 0000; no_write suppresses reg_write
        set_d(4'b1110, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
        tick();
        check("no_self_flush", {7'b0, e_valid}, 8'h01);
        alu_flags = 4'b0000;
        #1;
        check("cmp0_reg_write", {7'b0, reg_write}, 8'h00);

        // MOVEQ with Z=0 fails: no strobes and no flag update
        set_d(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
        tick();
        alu_flags = 4'b1111;
        #1;
        check("moveq_flags_pre", {4'b0, flags}, 8'h00);
        check("moveq_cond_ex", {7'b0, cond_ex}, 8'h00);
        check("moveq_reg_write", {7'b0, reg_write}, 8'h00);

        // CMP producing N=1
        set_d(4'b1110, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
        tick();
        check("moveq_flags_held", {4'b0, flags}, 8'h00);
        alu_flags = 4'b1000;
        #1;
        check("cmp1_reg_write", {7'b0, reg_write}, 8'h00);

        // GE fails and LT passes with N=1, V=0
        set_d(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();
        check("cmp1_flags", {4'b0, flags}, 8'h08);
        check("ge_cond_ex", {7'b0, cond_ex}, 8'h00);
        check("ge_reg_write", {7'b0, reg_write}, 8'h00);
        set_d(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();
        check("lt_cond_ex", {7'b0, cond_ex}, 8'h01);
        check("lt_reg_write", {7'b0, reg_write}, 8'h01);

        // Partial flag writes: C,V only then N,Z only
        set_d(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        tick();
        alu_flags = 4'b0111;
        set_d(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        tick();
        check("cv_only_flags", {4'b0, flags}, 8'h0B);
        alu_flags = 4'b0100;
        set_d(4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11);
        tick();
        check("nz_only_flags", {4'b0, flags}, 8'h07);

        // STR with flag_w=11 held under stall for 3 cycles
        alu_flags = 4'b1100;
        stall = 1'b1;
        set_d(4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_mem_write", {7'b0, mem_write}, 8'h00);
            check("stall_flags", {4'b0, flags}, 8'h07);
            tick();
        end
        check("stall_hold_valid", {7'b0, e_valid}, 8'h01);
        stall = 1'b0;
        #1;
        check("release_mem_write", {7'b0, mem_write}, 8'h01);
        set_d(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        tick();
        check("after_mem_write", {7'b0, mem_write}, 8'h00);
        check("str_flags", {4'b0, flags}, 8'h0C);

        // Flush together with stall while ADDS sits in E
        set_d(4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
        tick();
        alu_flags = 4'b0011;
        stall = 1'b1;
        flush = 1'b1;
        #1;
        check("fs_reg_write_now", {7'b0, reg_write}, 8'h00);
        tick();
        check("fs_valid", {7'b0, e_valid}, 8'h00);
        check("fs_strobes", {5'b0, pc_src, reg_write, mem_write}, 8'h00);
        check("fs_flags", {4'b0, flags}, 8'h0C);
        stall = 1'b0;
        flush = 1'b0;

        // Condition spot checks with flags N=1 Z=1 C=0 V=0
        probe_cond(4'b0001, "ne_cond_ex", 1'b0);
        probe_cond(4'b1001, "ls_cond_ex", 1'b1);
        probe_cond(4'b1000, "hi_cond_ex", 1'b0);
        probe_cond(4'b1101, "le_cond_ex", 1'b1);
        probe_cond(4'b0100, "mi_cond_ex", 1'b1);
        probe_cond(4'b1111, "nv_cond_ex", 1'b0);
        check("nv_reg_write", {7'b0, reg_write}, 8'h00);

        // Reset during flush restores the reset state
        flush = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        #1;
        check("rst2_valid", {7'b0, e_valid}, 8'h00);
        check("rst2_flags", {4'b0, flags}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
